// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: drives the four
// inter-stage register enable/flush pairs and the PC write enable.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_halt,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state;
  logic             ihit_held;
  logic             dmem_busy;
  logic             load_use;
  logic             fetch_ok;
  logic             run_advance;
  logic [CNT_W-1:0] stall_next;

  assign dmem_busy   = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use    = ex_dREN & (ex_wsel != 5'd0) &
                       ((ex_wsel == id_rs) | (ex_wsel == id_rt));
  assign fetch_ok    = ihit | ihit_held;
  assign run_advance = ~dmem_busy & ~ex_redirect & ~load_use & fetch_ok;
  assign stall_next  = (stall_cnt == {CNT_W{1'b1}}) ? stall_cnt : stall_cnt + CNT_W'(1);

  // Priority order matters: a data-memory stall freezes everything, even a redirect.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    if (!nRST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (dmem_busy) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
          end else if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (load_use) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (!fetch_ok) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        DRAIN: begin
          if (dmem_busy) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
          end else begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ihit_held remembers a fetch that landed while the PC was frozen by the back end.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      ihit_held <= 1'b0;
      halt      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!pc_en) stall_cnt <= stall_next;
          if (pc_en) ihit_held <= 1'b0;
          else if (ihit) ihit_held <= 1'b1;
          if (run_advance && id_halt) state <= DRAIN;
        end
        DRAIN: begin
          ihit_held <= 1'b0;
          if (!pc_en) stall_cnt <= stall_next;
          if (wb_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end
        end
        default: ihit_held <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then random traffic,
// all compared against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int CW = 5;
  localparam int HOLD = 0, ADV = 1, BUB = 2;
  localparam int S_RUN = 0, S_DRAIN = 1, S_HALTED = 2;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          ihit = 1'b0, dhit = 1'b0;
  logic          mem_dREN = 1'b0, mem_dWEN = 1'b0, ex_dREN = 1'b0;
  logic [4:0]    ex_wsel = '0, id_rs = '0, id_rt = '0;
  logic          id_halt = 1'b0, ex_redirect = 1'b0, wb_halt = 1'b0;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic          exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [CW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  int m_state = S_RUN;
  bit m_held  = 1'b0;
  bit m_halt  = 1'b0;
  int m_cnt   = 0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_halt(id_halt),
    .ex_redirect(ex_redirect), .wb_halt(wb_halt), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] observed();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en, memwb_flush};
  endfunction

  // Flush bits only matter where the register is enabled, except in reset.
  task automatic model_expected(output logic [8:0] e, output logic [8:0] m);
    int act[4];
    bit pc, busy, lu;
    busy = (mem_dREN || mem_dWEN) && !dhit;
    lu   = ex_dREN && (ex_wsel != 0) && (ex_wsel == id_rs || ex_wsel == id_rt);
    pc   = 1'b0;
    act  = '{ADV, ADV, ADV, ADV};
    if (m_state == S_HALTED)           act = '{HOLD, HOLD, HOLD, HOLD};
    else if (busy)                     act = '{HOLD, HOLD, HOLD, BUB};
    else if (m_state == S_DRAIN)       act = '{BUB, ADV, ADV, ADV};
    else if (ex_redirect) begin pc = 1'b1; act = '{BUB, BUB, ADV, ADV}; end
    else if (lu)                       act = '{HOLD, BUB, ADV, ADV};
    else if (!(ihit || m_held))        act = '{BUB, ADV, ADV, ADV};
    else                               pc = 1'b1;
    e = '0;
    m = '0;
    e[8] = pc;
    m[8] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e[7-2*i] = (act[i] != HOLD);
      e[6-2*i] = (act[i] == BUB);
      m[7-2*i] = 1'b1;
      m[6-2*i] = (act[i] != HOLD);
    end
    if (!nRST) begin
      e = 9'b0_01_01_01_01;
      m = '1;
    end
  endtask

  task automatic model_advance(input bit pc);
    int sat;
    sat = (1 << CW) - 1;
    if (!nRST) return;
    if (m_state == S_RUN) begin
      if (!pc && m_cnt < sat) m_cnt++;
      if (pc && !ex_redirect && id_halt) m_state = S_DRAIN;
      if (pc) m_held = 1'b0;
      else if (ihit) m_held = 1'b1;
    end else if (m_state == S_DRAIN) begin
      if (m_cnt < sat) m_cnt++;
      m_held = 1'b0;
      if (wb_halt) begin
        m_state = S_HALTED;
        m_halt  = 1'b1;
      end
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic ih, input logic dh,
                                input logic mrd, input logic mwr, input logic exr,
                                input logic [4:0] ws, input logic [4:0] rs,
                                input logic [4:0] rt, input logic idh,
                                input logic red, input logic wbh);
    @(negedge CLK);
    nRST = rst; ihit = ih; dhit = dh; mem_dREN = mrd; mem_dWEN = mwr;
    ex_dREN = exr; ex_wsel = ws; id_rs = rs; id_rt = rt;
    id_halt = idh; ex_redirect = red; wb_halt = wbh;
    if (!rst) begin
      m_state = S_RUN; m_held = 1'b0; m_halt = 1'b0; m_cnt = 0;
    end
  endtask

  task automatic check_output();
    logic [8:0] e, m;
    #1;
    model_expected(e, m);
    check("ctrl", 32'(observed() & m), 32'(e & m));
    check("halt", 32'(halt), 32'(m_halt));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    model_advance(e[8]);
  endtask

  task automatic step(input logic rst, input logic ih, input logic dh,
                      input logic mrd, input logic mwr, input logic exr,
                      input logic [4:0] ws, input logic [4:0] rs,
                      input logic [4:0] rt, input logic idh,
                      input logic red, input logic wbh);
    apply_stimulus(rst, ih, dh, mrd, mwr, exr, ws, rs, rt, idh, red, wbh);
    check_output();
  endtask

  initial begin
    // Reset, then straight-line execution
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 8, 8, 8, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    check("straight_cnt", 32'(stall_cnt), 0);

    // Load-use on $t0: one bubble
    step(1, 1, 1, 0, 0, 1, 8, 8, 3, 0, 0, 0);
    check("lu_pc_en", 32'(pc_en), 0);
    check("lu_idex_flush", 32'(idex_flush), 1);
    step(1, 1, 1, 0, 0, 0, 8, 8, 3, 0, 0, 0);
    check("lu_after_cnt", 32'(stall_cnt), 1);
    check("lu_after_pc_en", 32'(pc_en), 1);

    // Store stalled 3 cycles, ihit pulsed in the first
    step(1, 1, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0);
    check("st_memwb_flush", 32'(memwb_flush), 1);
    step(1, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 1, 2, 0, 0, 0);
    check("st_held_pc_en", 32'(pc_en), 1);
    check("st_cnt", 32'(stall_cnt), 4);

    // Redirect
    step(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 1, 0);
    check("rd_vec", 32'(observed()), 32'(9'b1_11_11_10_10));

    // Halt: 3 drain cycles, wb_halt in the third
    step(1, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 1, 0);
    check("dr_ifid_flush", 32'(ifid_flush), 1);
    step(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, i[0], i[1], 1, 0, 0, 0, 1, 2, 0, 0, 0);
    check("halted_halt", 32'(halt), 1);
    check("halted_pc_en", 32'(pc_en), 0);

    // Reset in the middle of DRAIN with stall_cnt=5
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    check("dr_cnt5", 32'(stall_cnt), 5);
    step(0, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    check("rst_vec", 32'(observed()), 32'(9'b0_01_01_01_01));
    check("rst_cnt", 32'(stall_cnt), 0);
    step(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    check("rst_run_pc_en", 32'(pc_en), 1);

    // Random traffic, biased towards hazards and halts
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline. Drives the enable/flush pair of each of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves instruction- and data-memory wait states, load-use hazards, EX-stage control redirects and the halt drain in one place. It also keeps a fetch-hit hold flag, a halt FSM and a stall-cycle counter.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch for current PC completes this cycle
- dhit  in  1  data access of MEM-stage instruction completes this cycle
- mem_dREN, mem_dWEN  in  1 each  EX/MEM outputs: MEM stage holds a load/store
- ex_dREN  in  1  ID/EX output: EX stage holds a load
- ex_wsel  in  5  ID/EX output: EX-stage destination register
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_halt  in  1  ID decodes HALT
- ex_redirect  in  1  EX resolved a taken branch or jump
- wb_halt  in  1  MEM/WB halt output
- pc_en  out  1  PC register write enable
- ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush  out  1 each  pipe register controls; flush has effect only when the matching en=1
- halt  out  1  sticky processor-halted flag
- stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN or DRAIN, saturating

## Operation
- State: FSM {RUN, DRAIN, HALTED}. Registers: ihit_held, halt, stall_cnt.
- Reset values: state=RUN, ihit_held=0, halt=0, stall_cnt=0.
- While nRST=0: every en=0, every flush=1, pc_en=0.
- RUN: the first matching rule below decides the cycle.
  1. dmem busy, (mem_dREN|mem_dWEN)&!dhit: pc_en, ifid_en, idex_en, exmem_en=0; memwb_en=1, memwb_flush=1.
  2. ex_redirect: pc_en=1; ifid and idex en=1 with flush=1; exmem and memwb advance.
  3. load-use, ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt): pc_en=0, ifid_en=0; idex en=1 with flush=1; exmem and memwb advance.
  4. fetch miss, !(ihit|ihit_held): pc_en=0; ifid en=1 with flush=1; the rest advance.
  5. Otherwise all en=1, all flush=0, pc_en=1. If id_halt=1 as well, next state is DRAIN.
- "Advance" means en=1, flush=0.
- ihit_held:
  - Set when ihit=1 and pc_en=0 in RUN.
  - Cleared whenever pc_en=1, and on leaving RUN.
  - Lets a fetch that completed during a back-end stall count as a hit later.
- DRAIN:
  - pc_en=0; ifid en=1 with flush=1, so bubbles replace fetches.
  - Rule 1 (dmem busy) still applies.
  - Otherwise idex, exmem and memwb advance.
  - ex_redirect is ignored, because the halt is older than any instruction behind it.
  - wb_halt=1 moves the FSM to HALTED.
- HALTED: every en=0, pc_en=0. halt=1 until reset. ihit and dhit are ignored.
- stall_cnt increments by 1 on each clock where state is RUN or DRAIN and pc_en=0. It holds at 2^CNT_W-1.
- Reset mid-operation: all registers return to reset values asynchronously. No pending stall or hold is carried over.

## Timing
- All en/flush/pc_en outputs are combinational from the current state, ihit_held and inputs. They take effect at the next CLK edge.
- Load-use costs exactly 1 bubble cycle. On the next cycle ex_dREN=0, so the hazard clears.
- Redirect costs 2 flushed slots (IF/ID, ID/EX) and has no extra stall.
- halt rises on the CLK edge that samples wb_halt=1 in DRAIN, one cycle after wb_halt asserts.
- dmem busy and a simultaneous ex_redirect: the stall wins. The redirect is held in EX and takes effect on the first cycle with dhit=1.
- dhit and load-use in the same cycle: rule 3 applies (the back end advances).

## Test plan
- Straight line, ihit=1 and dhit=1 every cycle -> all en=1, flush=0, pc_en=1 every cycle; stall_cnt stays 0.
- Load to $t0 in EX with id_rs=8, ex_wsel=8 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle all advance; stall_cnt=1.
- Store in MEM with dhit low for 3 cycles:
  - With ihit pulsed in cycle 1 -> memwb_flush=1 for 3 cycles, ihit_held=1 from cycle 2.
  - Cycle 4 (dhit=1, ihit=0) -> full advance.
  - stall_cnt=3.
- ex_redirect=1 with ihit=1 -> pc_en=1, ifid_flush=1, idex_flush=1, exmem_flush=0.
- id_halt=1 with wb_halt asserted 3 cycles later -> DRAIN for 3 cycles with ifid_flush=1 and pc_en=0. halt=1 on the next edge, then all en=0. Toggling ihit/dhit leaves halt=1.
- nRST driven low mid-DRAIN with stall_cnt=5 -> immediately all en=0, flush=1. After release: RUN, halt=0, stall_cnt=0.
